// File: rtl/lexington.sv
// Shared writeback types: register address, data word, slow-path FIFO entry,
// and a helper for reading the x1..x31 pending vector.
package lexington;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word;

  typedef struct packed {
    reg_addr_t addr;
    word       data;
  } wb_entry_t;

  localparam int WB_FIFO_DEPTH = 2;

  // The scoreboard has no bit for x0, so reading x0 always returns 0.
  function automatic logic pend_bit(input logic [31:1] pend, input reg_addr_t a);
    logic [31:0] v;
    v = {pend, 1'b0};
    return v[a];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO for slow-path writeback entries.
// A push while full is dropped; a pop while empty is ignored.
module wb_fifo
  import lexington::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // DEPTH is a power of two, so pointers wrap naturally.
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU path has strict priority over the buffered slow path;
// tracks pending long-latency destinations. Optional: LEXINGTON_WB_FWD_EN.
module wb_arbiter
  import lexington::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_addr,
  input  logic [31:0] lsu_data,
  input  logic        issue_en,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
`ifdef LEXINGTON_WB_FWD_EN
  output logic        rs1_fwd_en,
  output logic [31:0] rs1_fwd_data,
  output logic        rs2_fwd_en,
  output logic [31:0] rs2_fwd_data,
`endif
  output logic        dest_en,
  output logic [4:0]  dest_addr,
  output logic [31:0] dest_data
);

  logic        dest_en_q,       dest_en_d;
  reg_addr_t   dest_addr_q,     dest_addr_d;
  word         dest_data_q,     dest_data_d;
  logic        dest_from_lsu_q, dest_from_lsu_d;
  logic [31:1] pending_q,       pending_d;

  logic        fifo_full, fifo_empty;
  logic        lsu_push, lsu_pop;
  wb_entry_t   fifo_head, fifo_in;
  logic        sb_set, sb_clr;
  logic        rs1_pend, rs2_pend;

  assign fifo_in = '{addr: lsu_addr, data: lsu_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (lsu_push),
    .push_entry (fifo_in),
    .pop        (lsu_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // Selection: ALU first, then FIFO head. x0 targets are consumed but not written.
  always_comb begin
    lsu_ready       = !rst && !fifo_full;
    lsu_push        = lsu_valid && lsu_ready;
    lsu_pop         = !alu_valid && !fifo_empty;
    dest_en_d       = 1'b0;
    dest_addr_d     = dest_addr_q;
    dest_data_d     = dest_data_q;
    dest_from_lsu_d = 1'b0;
    if (alu_valid) begin
      dest_en_d   = (alu_addr != '0);
      dest_addr_d = alu_addr;
      dest_data_d = alu_data;
    end else if (!fifo_empty) begin
      dest_en_d       = (fifo_head.addr != '0);
      dest_addr_d     = fifo_head.addr;
      dest_data_d     = fifo_head.data;
      dest_from_lsu_d = 1'b1;
    end
  end

  // Scoreboard: a slow write clears its bit as it lands; a same-cycle issue wins.
  always_comb begin
    sb_set    = issue_en && (issue_addr != '0);
    sb_clr    = dest_en_q && dest_from_lsu_q;
    pending_d = pending_q;
    for (int i = 1; i < 32; i++) begin
      if (sb_clr && (dest_addr_q == 5'(i))) pending_d[i] = 1'b0;
      if (sb_set && (issue_addr == 5'(i)))  pending_d[i] = 1'b1;
    end
  end

  always_comb begin
    rs1_pend = pend_bit(pending_q, rs1_addr);
    rs2_pend = pend_bit(pending_q, rs2_addr);
`ifdef LEXINGTON_WB_FWD_EN
    rs1_fwd_en   = dest_en_q && (dest_addr_q == rs1_addr) && (rs1_addr != '0);
    rs2_fwd_en   = dest_en_q && (dest_addr_q == rs2_addr) && (rs2_addr != '0);
    rs1_fwd_data = dest_data_q;
    rs2_fwd_data = dest_data_q;
    // The bit drops at this edge unless re-issued, so the forwarded value is final.
    rs1_busy = rs1_pend && !(rs1_fwd_en && dest_from_lsu_q &&
                             !(sb_set && (issue_addr == rs1_addr)));
    rs2_busy = rs2_pend && !(rs2_fwd_en && dest_from_lsu_q &&
                             !(sb_set && (issue_addr == rs2_addr)));
`else
    rs1_busy = rs1_pend;
    rs2_busy = rs2_pend;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_en_q       <= 1'b0;
      dest_addr_q     <= '0;
      dest_data_q     <= '0;
      dest_from_lsu_q <= 1'b0;
      pending_q       <= '0;
    end else begin
      dest_en_q       <= dest_en_d;
      dest_addr_q     <= dest_addr_d;
      dest_data_q     <= dest_data_d;
      dest_from_lsu_q <= dest_from_lsu_d;
      pending_q       <= pending_d;
    end
  end

  assign dest_en   = dest_en_q;
  assign dest_addr = dest_addr_q;
  assign dest_data = dest_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: priority, buffering, scoreboard, x0, reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        dest_en;
  logic [4:0]  dest_addr;
  logic [31:0] dest_data;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_addr   (lsu_addr),
    .lsu_data   (lsu_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .dest_en    (dest_en),
    .dest_addr  (dest_addr),
    .dest_data  (dest_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 0; alu_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    issue_en = 0; issue_addr = 0; rs1_addr = 5'd3; rs2_addr = 5'd4;
    tick();
    ncmp++; if (dest_en !== 1'b0) begin nerr++; $display("FAIL rst_dest_en got %b exp 0", dest_en); end
    ncmp++; if (dest_addr !== 5'd0) begin nerr++; $display("FAIL rst_dest_addr got %0d exp 0", dest_addr); end
    ncmp++; if (dest_data !== 32'd0) begin nerr++; $display("FAIL rst_dest_data got %h exp 0", dest_data); end
    ncmp++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL rst_lsu_ready got %b exp 0", lsu_ready); end
    ncmp++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b%b exp 00", rs1_busy, rs2_busy); end
    rst = 1'b0; #1;
    ncmp++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_lsu_ready got %b exp 1", lsu_ready); end
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0; #1;
    ncmp++; if (dest_en !== 1'b1) begin nerr++; $display("FAIL alu_en got %b exp 1", dest_en); end
    ncmp++; if (dest_addr !== 5'd5) begin nerr++; $display("FAIL alu_addr got %0d exp 5", dest_addr); end
    ncmp++; if (dest_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL alu_data got %h exp deadbeef", dest_data); end
    ncmp++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL alu_lsu_ready got %b exp 1", lsu_ready); end
    tick();
    ncmp++; if (dest_en !== 1'b0) begin nerr++; $display("FAIL alu_idle_en got %b exp 0", dest_en); end
  endtask

  task automatic test_priority();
    alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h33;
    lsu_valid = 1; lsu_addr = 5'd7; lsu_data = 32'h11;
    tick();
    alu_addr = 5'd4; alu_data = 32'h44;
    lsu_addr = 5'd8; lsu_data = 32'h22;
    ncmp++; if (dest_addr !== 5'd3 || dest_en !== 1'b1) begin nerr++; $display("FAIL prio_alu0 got en=%b addr=%0d exp en=1 addr=3", dest_en, dest_addr); end
    tick();
    lsu_valid = 0; alu_addr = 5'd6; alu_data = 32'h66;
    ncmp++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL prio_full got %b exp 0", lsu_ready); end
    ncmp++; if (dest_addr !== 5'd4) begin nerr++; $display("FAIL prio_alu1 got %0d exp 4", dest_addr); end
    tick();
    alu_valid = 0;
    ncmp++; if (dest_addr !== 5'd6 || lsu_ready !== 1'b0) begin nerr++; $display("FAIL prio_alu2 got addr=%0d rdy=%b exp addr=6 rdy=0", dest_addr, lsu_ready); end
    tick();
    ncmp++; if (dest_en !== 1'b1 || dest_addr !== 5'd7 || dest_data !== 32'h11) begin nerr++; $display("FAIL prio_pop7 got en=%b addr=%0d data=%h exp 1/7/11", dest_en, dest_addr, dest_data); end
    ncmp++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL prio_ready_after_pop got %b exp 1", lsu_ready); end
    tick();
    ncmp++; if (dest_en !== 1'b1 || dest_addr !== 5'd8 || dest_data !== 32'h22) begin nerr++; $display("FAIL prio_pop8 got en=%b addr=%0d data=%h exp 1/8/22", dest_en, dest_addr, dest_data); end
    tick();
    ncmp++; if (dest_en !== 1'b0) begin nerr++; $display("FAIL prio_drained got %b exp 0", dest_en); end
  endtask

  task automatic test_scoreboard();
    issue_en = 1; issue_addr = 5'd9;
    tick();
    issue_en = 0; rs1_addr = 5'd9; #1;
    ncmp++; if (rs1_busy !== 1'b1) begin nerr++; $display("FAIL sb_set got %b exp 1", rs1_busy); end
    lsu_valid = 1; lsu_addr = 5'd9; lsu_data = 32'h5;
    tick();
    lsu_valid = 0;
    tick();
    ncmp++; if (dest_en !== 1'b1 || dest_addr !== 5'd9 || dest_data !== 32'h5) begin nerr++; $display("FAIL sb_write got en=%b addr=%0d data=%h exp 1/9/5", dest_en, dest_addr, dest_data); end
    ncmp++; if (rs1_busy !== 1'b1) begin nerr++; $display("FAIL sb_busy_during_write got %b exp 1", rs1_busy); end
    tick();
    ncmp++; if (rs1_busy !== 1'b0) begin nerr++; $display("FAIL sb_clear got %b exp 0", rs1_busy); end
    issue_en = 1; issue_addr = 5'd9;
    tick();
    issue_en = 0; alu_valid = 1; alu_addr = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    ncmp++; if (dest_en !== 1'b1 || dest_addr !== 5'd9) begin nerr++; $display("FAIL sb_alu_write got en=%b addr=%0d exp 1/9", dest_en, dest_addr); end
    tick();
    ncmp++; if (rs1_busy !== 1'b1) begin nerr++; $display("FAIL sb_alu_noclear got %b exp 1", rs1_busy); end
  endtask

  task automatic test_x0();
    issue_en = 1; issue_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    issue_en = 0;
    ncmp++; if (rs2_busy !== 1'b0) begin nerr++; $display("FAIL x0_busy got %b exp 0", rs2_busy); end
    alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFF;
    tick();
    alu_valid = 0;
    ncmp++; if (dest_en !== 1'b0) begin nerr++; $display("FAIL x0_alu got %b exp 0", dest_en); end
    alu_valid = 1; alu_addr = 5'd1; alu_data = 32'h1;
    lsu_valid = 1; lsu_addr = 5'd0; lsu_data = 32'hAB;
    tick();
    lsu_addr = 5'd10; lsu_data = 32'h10;
    tick();
    lsu_valid = 0; alu_valid = 0;
    ncmp++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL x0_full got %b exp 0", lsu_ready); end
    tick();
    ncmp++; if (dest_en !== 1'b0 || lsu_ready !== 1'b1) begin nerr++; $display("FAIL x0_lsu_pop got en=%b rdy=%b exp en=0 rdy=1", dest_en, lsu_ready); end
    tick();
    ncmp++; if (dest_en !== 1'b1 || dest_addr !== 5'd10 || dest_data !== 32'h10) begin nerr++; $display("FAIL x0_next got en=%b addr=%0d data=%h exp 1/10/10", dest_en, dest_addr, dest_data); end
    tick();
  endtask

  task automatic test_collision();
    issue_en = 1; issue_addr = 5'd12;
    tick();
    issue_en = 0; rs2_addr = 5'd12;
    lsu_valid = 1; lsu_addr = 5'd12; lsu_data = 32'h77;
    tick();
    lsu_valid = 0;
    tick();
    ncmp++; if (dest_en !== 1'b1 || dest_addr !== 5'd12 || rs2_busy !== 1'b1) begin nerr++; $display("FAIL col_write got en=%b addr=%0d busy=%b exp 1/12/1", dest_en, dest_addr, rs2_busy); end
    issue_en = 1; issue_addr = 5'd12;
    tick();
    issue_en = 0;
    ncmp++; if (rs2_busy !== 1'b1) begin nerr++; $display("FAIL col_set_wins got %b exp 1", rs2_busy); end
    tick();
    ncmp++; if (rs2_busy !== 1'b1) begin nerr++; $display("FAIL col_hold got %b exp 1", rs2_busy); end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_addr = 5'd2; alu_data = 32'h2;
    lsu_valid = 1; lsu_addr = 5'd13; lsu_data = 32'h13;
    issue_en = 1; issue_addr = 5'd15;
    tick();
    lsu_addr = 5'd14; lsu_data = 32'h14; issue_en = 0;
    tick();
    ncmp++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL mid_full got %b exp 0", lsu_ready); end
    rs1_addr = 5'd9; rs2_addr = 5'd15; #1;
    ncmp++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin nerr++; $display("FAIL mid_pending got %b%b exp 11", rs1_busy, rs2_busy); end
    rst = 1; alu_valid = 0; lsu_valid = 0;
    tick();
    ncmp++; if (dest_en !== 1'b0 || dest_addr !== 5'd0 || dest_data !== 32'd0) begin nerr++; $display("FAIL mid_rst_dest got en=%b addr=%0d data=%h exp 0/0/0", dest_en, dest_addr, dest_data); end
    ncmp++; if (lsu_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_ready got %b exp 0", lsu_ready); end
    rst = 0; #1;
    ncmp++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin nerr++; $display("FAIL mid_busy got %b%b exp 00", rs1_busy, rs2_busy); end
    rs2_addr = 5'd12; #1;
    ncmp++; if (rs2_busy !== 1'b0) begin nerr++; $display("FAIL mid_busy12 got %b exp 0", rs2_busy); end
    ncmp++; if (lsu_ready !== 1'b1) begin nerr++; $display("FAIL mid_ready got %b exp 1", lsu_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      ncmp++; if (dest_en !== 1'b0) begin nerr++; $display("FAIL mid_no_write[%0d] got en=%b addr=%0d exp en=0", i, dest_en, dest_addr); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_priority();
    test_scoreboard();
    test_x0();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
